// File: rtl/router_pkg.sv
// Shared router types and constants: port count, word width, arbiter state
// encoding and a modulo pointer helper used by the output arbiters.
package router_pkg;

  localparam int N_PORTS = 8;
  localparam int DATA_W  = 32;
  localparam int PORT_W  = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef logic [DATA_W-1:0] word_t;

  // Advance a requester index modulo n, so non-power-of-2 port counts wrap correctly.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request bit at or
// after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N     = 8,
  parameter int PTR_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic [PTR_W-1:0] winner
);

  // Scan from the farthest offset down so the nearest requester after ptr is kept.
  always_comb begin
    int idx;
    valid  = 1'b0;
    winner = {PTR_W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      idx    = (int'(ptr) + i) % N;
      valid  = req[idx] ? 1'b1 : valid;
      winner = req[idx] ? PTR_W'(idx) : winner;
    end
  end

endmodule

// File: rtl/router_out_arbiter.sv
// Output-port scheduler: round-robin packet-locked arbitration over N_REQ
// show-ahead input queues, registered push into the output FIFO, stall watchdog.
module router_out_arbiter #(
  parameter int N_REQ    = router_pkg::N_PORTS,
  parameter int DATA_W   = router_pkg::DATA_W,
  parameter int PTR_W    = router_pkg::PORT_W,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  input  logic [N_REQ-1:0]        last_in,
  input  logic                    out_full,
  output logic [N_REQ-1:0]        pop,
  output logic [N_REQ-1:0]        grant,
  output logic [DATA_W-1:0]       dataout,
  output logic                    push,
  output logic                    timeout_err
);

  import router_pkg::*;

  arb_state_t          state_r;
  logic [N_REQ-1:0]    grant_r;
  logic [PTR_W-1:0]    ptr_r;
  logic [PTR_W-1:0]    owner_r;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic [DATA_W-1:0]   dataout_r;
  logic                push_r;
  logic                timeout_err_r;

  logic                pick_valid_s;
  logic [PTR_W-1:0]    pick_idx_s;
  logic                pop_en_s;
  logic [N_REQ-1:0]    pop_s;
  logic [DATA_W-1:0]   head_data_s;
  logic [PTR_W-1:0]    next_ptr_s;

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr_r),
    .valid  (pick_valid_s),
    .winner (pick_idx_s)
  );

  // Pop strobe to the owner's queue, the owner's head word and the post-packet pointer.
  always_comb begin
    pop_s = {N_REQ{1'b0}};
    if (reset_n && (state_r == LOCKED)) begin
      pop_en_s = req[owner_r] & ~out_full;
    end else begin
      pop_en_s = 1'b0;
    end
    pop_s[owner_r] = pop_en_s;
    head_data_s    = data_in[int'(owner_r)*DATA_W +: DATA_W];
    next_ptr_s     = PTR_W'(wrap_inc(int'(owner_r), N_REQ));
  end

  // Arbitration FSM with registered grant, output word/push and watchdog.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      grant_r       <= {N_REQ{1'b0}};
      ptr_r         <= {PTR_W{1'b0}};
      owner_r       <= {PTR_W{1'b0}};
      wait_cnt_r    <= {WAIT_W{1'b0}};
      dataout_r     <= {DATA_W{1'b0}};
      push_r        <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          push_r <= 1'b0;
          if (pick_valid_s) begin
            state_r    <= LOCKED;
            grant_r    <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx_s;
            owner_r    <= pick_idx_s;
            wait_cnt_r <= {WAIT_W{1'b0}};
          end
        end
        LOCKED: begin
          if (pop_en_s) begin
            push_r     <= 1'b1;
            dataout_r  <= head_data_s;
            wait_cnt_r <= {WAIT_W{1'b0}};
            if (last_in[owner_r]) begin
              state_r <= IDLE;
              grant_r <= {N_REQ{1'b0}};
              ptr_r   <= next_ptr_s;
            end
          end else begin
            push_r <= 1'b0;
            // Backpressure is the output's fault, not the requester's: never count it.
            if (out_full) begin
              wait_cnt_r <= {WAIT_W{1'b0}};
            end else if (wait_cnt_r == WAIT_W'(MAX_WAIT - 1)) begin
              state_r       <= IDLE;
              grant_r       <= {N_REQ{1'b0}};
              ptr_r         <= next_ptr_s;
              wait_cnt_r    <= {WAIT_W{1'b0}};
              timeout_err_r <= 1'b1;
            end else begin
              wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end
          end
        end
        default: begin
          state_r <= IDLE;
          grant_r <= {N_REQ{1'b0}};
          push_r  <= 1'b0;
        end
      endcase
    end
  end

  assign pop         = pop_s;
  assign grant       = grant_r;
  assign dataout     = dataout_r;
  assign push        = push_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: doc/router_out_arbiter.md
Name: router_out_arbiter

Overview:
- Per-output-port scheduler for the router. Shares one output port queue among N_REQ input-port queues.
- Input queues are show-ahead FIFOs, each holding words already routed to this output.
- Grants with round-robin priority and holds the grant for a whole packet, up to the word flagged last.
- Pops the granted input queue and drives a registered word/push pair into the output port FIFO, with backpressure and a stalled-packet watchdog.

Parameters:
- N_REQ, 8, number of requesting input ports.
- DATA_W, 32, word width.
- PTR_W, 3, width of the requester index; equals clog2(N_REQ).
- MAX_WAIT, 15, consecutive idle cycles tolerated from a granted requester mid-packet before the lock is dropped.
- WAIT_W, 4, width of the wait counter; must hold MAX_WAIT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- req  in  N_REQ  bit i: queue i is non-empty.
- data_in  in  N_REQ*DATA_W  head word of queue i at bits [i*DATA_W +: DATA_W].
- last_in  in  N_REQ  bit i: head word of queue i ends a packet.
- out_full  in  1  output FIFO almost-full; asserted when at most 1 entry is free.
- pop  out  N_REQ  combinational read strobe to queue i.
- grant  out  N_REQ  registered one-hot lock owner; all zero when idle.
- dataout  out  DATA_W  registered word to the output FIFO.
- push  out  1  registered write strobe to the output FIFO.
- timeout_err  out  1  sticky flag: the watchdog has fired; cleared only by reset.

Behaviour:
- Reset, when reset_n=0 at a clock edge:
  - state=IDLE, grant=0, ptr=0, wait_cnt=0.
  - dataout=0, push=0, timeout_err=0.
  - pop is forced to 0 while reset_n=0.
- Reset wins over every other event. A partial packet in flight is abandoned and no further words of it are pushed.
- State IDLE:
  - pop=0.
  - If req is non-zero, pick the winner w: the first set bit of req searching ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1.
  - Next cycle: grant=onehot(w), state=LOCKED, wait_cnt=0.
  - If req is zero, stay in IDLE.
  - There is 1 cycle of arbitration overhead per packet.
- State LOCKED, owner g:
  - pop[g] = req[g] & ~out_full. All other pop bits are 0.
  - On pop: dataout <= data_in[g] and push <= 1 at the next edge, so push follows pop by one cycle.
  - On any cycle without pop: push <= 0 and dataout holds its value.
  - Pop with last_in[g]=1: next cycle state=IDLE, grant=0, ptr=(g+1) mod N_REQ. The pointer wraps 7→0.
  - req[g]=0 while out_full=0: wait_cnt increments.
  - Pop, or out_full=1: wait_cnt clears to 0. Backpressure never counts toward the timeout.
  - wait_cnt reaching MAX_WAIT: next cycle state=IDLE, grant=0, ptr=(g+1) mod N_REQ, timeout_err=1. No push is generated.
- Other requesters asserting req during LOCKED have no effect until the lock is released.
- Single-word packet (last set on the first word): LOCKED lasts exactly 1 cycle.
- out_full asserted while the push of the previous word is in flight: the slack entry absorbs that word, so no word is lost or duplicated.
- Widths: ptr increment is modulo N_REQ, not a natural binary wrap, so non-power-of-2 N_REQ also works.
- Throughput: 1 word per cycle sustained inside a packet.

Decomposition:
- Package router_pkg holds:
  - constants N_PORTS=8, DATA_W=32, PORT_W=3;
  - arb_state_t enum {IDLE, LOCKED};
  - the word type shared with the existing selector/demux path.
- Sub-module rr_pick: purely combinational round-robin priority encoder.
  - Inputs: req, ptr.
  - Outputs: valid, winner index.
  - Reused by other arbiters in the router.

Test Plan:
- Queue 2 only, 3-word packet A,B,C with last on C, out_full=0 → grant=0x04 one cycle after req; pop[2] on 3 consecutive cycles; push with A,B,C on the following 3 cycles; then grant=0, ptr=3.
- req=0x81 at ptr=0, each queue holding a 2-word packet → queue 0 served first; queue 7 then served; ptr ends at 0 (wrap). Output order is 0,0,7,7 with no interleaving.
- out_full held high for 4 cycles mid-packet on queue 1 → pop and push stay 0 during the stall and wait_cnt stays 0; the packet resumes intact with no duplicated or dropped word.
- Queue 5 granted, 1 word popped, then req[5]=0 for 15 cycles → timeout_err=1, grant=0, ptr=6; a waiting req[3] is granted 1 cycle later.
- reset_n=0 for 1 cycle in the middle of a 4-word packet → next cycle grant=0, push=0, dataout=0, ptr=0; arbitration restarts from queue 0.
- All 8 req high, single-word packets → grants cycle 0,1,…,7,0; each packet takes 2 cycles.
